// File: rtl/ip_packet_pkg.sv
// Shared definitions for the IP packet transmit/receive path: header sizes,
// fixed header field values and the transmit state encoding.
package ip_packet_pkg;

  localparam int ETH_HDR_SIZE_BYTES = 14;
  localparam int IP_HDR_SIZE_BYTES  = 20;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_TTL         = 8'h40;
  localparam logic [7:0]  IP_PROTO       = 8'hFD;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CSUM,
    TX_ETH_HDR,
    TX_IP_HDR,
    TX_USER_DATA
  } tx_state_e;

endpackage

// File: rtl/counter_sync_reset.sv
// Up-counter with a synchronous clear (priority over enable) and an
// asynchronous active-high reset.
module counter_sync_reset #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/ip_header_checksum.sv
// IPv4 header checksum over the fixed-format header this block emits.
// Addresses arrive with wire byte 0 in bits [7:0].
module ip_header_checksum
  import ip_packet_pkg::*;
(
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_total_len,
  input  logic [15:0] i_id,
  output logic [15:0] o_csum
);

  logic [19:0] w_acc;
  logic [19:0] w_fold1;
  logic [15:0] w_fold2;

  // Nine non-zero words; the checksum word itself contributes zero.
  assign w_acc = 20'(16'h4500) + 20'(i_total_len) + 20'(i_id) + 20'(16'h4000)
               + 20'({IP_TTL, IP_PROTO})
               + 20'({i_src_ip[7:0],   i_src_ip[15:8]})
               + 20'({i_src_ip[23:16], i_src_ip[31:24]})
               + 20'({i_dst_ip[7:0],   i_dst_ip[15:8]})
               + 20'({i_dst_ip[23:16], i_dst_ip[31:24]});

  assign w_fold1 = {4'b0, w_acc[15:0]} + {16'b0, w_acc[19:16]};
  assign w_fold2 = w_fold1[15:0] + {12'b0, w_fold1[19:16]};
  assign o_csum  = ~w_fold2;

endmodule

// File: rtl/ip_packet_tx.sv
// Builds Ethernet II + IPv4 headers around one captured payload frame and
// streams the packet byte-wise into the MAC's 8-bit AXI-Stream port.
module ip_packet_tx
  import ip_packet_pkg::*;
#(
  parameter int USER_DATA_BYTES = 2,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0]                  DST_IP_ADDRESS,
  input  logic [47:0]                  DST_MAC_ADDRESS,
  input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
  input  logic                         FRAME_VALID,
  output logic                         FRAME_ACCEPT,
  output logic [7:0]                   MAC_DATA_IN,
  output logic                         MAC_DATA_VALID,
  input  logic                         MAC_DATA_READY,
  output logic                         MAC_DATA_LAST,
  output logic                         TX_BUSY
);

  localparam int CW = COUNTER_WIDTH;
  localparam logic [15:0]   TOTAL_LEN = 16'(IP_HDR_SIZE_BYTES + USER_DATA_BYTES);
  localparam logic [CW-1:0] ETH_LAST  = CW'(ETH_HDR_SIZE_BYTES - 1);
  localparam logic [CW-1:0] IP_LAST   = CW'(IP_HDR_SIZE_BYTES - 1);
  localparam logic [CW-1:0] USR_LAST  = CW'(USER_DATA_BYTES - 1);
  localparam logic [CW-1:0] USR_PEN   = CW'(USER_DATA_BYTES - 2);

  tx_state_e                    r_state;
  logic [USER_DATA_BYTES*8-1:0] r_frame;
  logic [31:0]                  r_src_ip, r_dst_ip;
  logic [47:0]                  r_src_mac, r_dst_mac;
  logic [15:0]                  r_id, r_id_cap, r_csum;
  logic                         r_valid, r_last;

  logic [CW-1:0] w_cnt, w_seg_last;
  logic [4:0]    w_idx;
  logic [2:0]    w_smac_sel;
  logic [15:0]   w_csum;
  logic [7:0]    w_byte;
  logic          w_hs, w_end, w_clr;

  assign w_hs  = r_valid && MAC_DATA_READY;
  assign w_end = w_hs && (w_cnt == w_seg_last);
  // Any state transition restarts the byte index of the next segment.
  assign w_clr = ((r_state == TX_IDLE) && FRAME_VALID) || (r_state == TX_CSUM) || w_end;

  always_comb begin
    case (r_state)
      TX_ETH_HDR:   w_seg_last = ETH_LAST;
      TX_IP_HDR:    w_seg_last = IP_LAST;
      TX_USER_DATA: w_seg_last = USR_LAST;
      default:      w_seg_last = '0;
    endcase
  end

  counter_sync_reset #(.WIDTH(CW)) u_byte_cnt (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_clr   (w_clr),
    .i_en    (w_hs),
    .o_count (w_cnt)
  );

  ip_header_checksum u_csum (
    .i_src_ip    (r_src_ip),
    .i_dst_ip    (r_dst_ip),
    .i_total_len (TOTAL_LEN),
    .i_id        (r_id_cap),
    .o_csum      (w_csum)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= TX_IDLE;
      r_frame   <= '0;
      r_src_ip  <= '0;
      r_dst_ip  <= '0;
      r_src_mac <= '0;
      r_dst_mac <= '0;
      r_id      <= '0;
      r_id_cap  <= '0;
      r_csum    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: if (FRAME_VALID) begin
          r_frame   <= DATA_FRAME;
          r_src_ip  <= ACCELERATOR_IP_ADDRESS;
          r_dst_ip  <= DST_IP_ADDRESS;
          r_src_mac <= ACCELERATOR_MAC_ADDRESS;
          r_dst_mac <= DST_MAC_ADDRESS;
          r_id_cap  <= r_id;
          r_state   <= TX_CSUM;
        end
        TX_CSUM: begin
          r_csum  <= w_csum;
          r_valid <= 1'b1;
          r_state <= TX_ETH_HDR;
        end
        TX_ETH_HDR: if (w_end) r_state <= TX_IP_HDR;
        TX_IP_HDR: if (w_end) begin
          r_state <= TX_USER_DATA;
          r_last  <= (USER_DATA_BYTES == 1);
        end
        TX_USER_DATA: if (w_end) begin
          r_state <= TX_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_id    <= r_id + 16'd1;
        end else if (w_hs && (w_cnt == USR_PEN)) begin
          r_last <= 1'b1;
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign w_idx      = w_cnt[4:0];
  assign w_smac_sel = 3'(w_idx - 5'd6);

  // Source/destination IP bytes start at 12 and 16, so w_idx[1:0] picks the byte.
  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      TX_ETH_HDR: begin
        if (w_idx < 5'd6)        w_byte = 8'(r_dst_mac >> {w_idx[2:0], 3'b000});
        else if (w_idx < 5'd12)  w_byte = 8'(r_src_mac >> {w_smac_sel, 3'b000});
        else if (w_idx == 5'd12) w_byte = ETHERTYPE_IPV4[15:8];
        else                     w_byte = ETHERTYPE_IPV4[7:0];
      end
      TX_IP_HDR: begin
        case (w_idx)
          5'd0:    w_byte = 8'h45;
          5'd2:    w_byte = TOTAL_LEN[15:8];
          5'd3:    w_byte = TOTAL_LEN[7:0];
          5'd4:    w_byte = r_id_cap[15:8];
          5'd5:    w_byte = r_id_cap[7:0];
          5'd6:    w_byte = 8'h40;
          5'd8:    w_byte = IP_TTL;
          5'd9:    w_byte = IP_PROTO;
          5'd10:   w_byte = r_csum[15:8];
          5'd11:   w_byte = r_csum[7:0];
          default: begin
            if (w_idx >= 5'd16)      w_byte = 8'(r_dst_ip >> {w_idx[1:0], 3'b000});
            else if (w_idx >= 5'd12) w_byte = 8'(r_src_ip >> {w_idx[1:0], 3'b000});
          end
        endcase
      end
      TX_USER_DATA: w_byte = 8'(r_frame >> {w_cnt, 3'b000});
      default:      w_byte = 8'h00;
    endcase
  end

  assign MAC_DATA_IN    = w_byte;
  assign MAC_DATA_VALID = r_valid;
  assign MAC_DATA_LAST  = r_last;
  assign FRAME_ACCEPT   = (r_state == TX_IDLE);
  assign TX_BUSY        = (r_state != TX_IDLE);

endmodule

// File: tb/tb_ip_packet_tx.sv
// Directed bench for ip_packet_tx: table of packets with hand-computed header
// fields, plus sequences for capture isolation, ID wrap and mid-packet reset.
module tb_ip_packet_tx;

  localparam int UDB = 2;
  localparam int PKT = 36;
  localparam logic [31:0] SRC_IP = 32'h0A01A8C0;
  localparam logic [47:0] SRC_MAC = 48'h010000000002;
  localparam logic [47:0] DMAC_A = 48'hFFEEDDCCBBAA;
  localparam logic [31:0] DIP_A = 32'h0101A8C0;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [31:0]     DST_IP_ADDRESS;
  logic [47:0]     DST_MAC_ADDRESS;
  logic [UDB*8-1:0] DATA_FRAME;
  logic            FRAME_VALID, FRAME_ACCEPT;
  logic [7:0]      MAC_DATA_IN;
  logic            MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST, TX_BUSY;

  ip_packet_tx #(.USER_DATA_BYTES(UDB), .COUNTER_WIDTH(16)) dut (
    .ACLK                    (ACLK),
    .ARESET                  (ARESET),
    .ACCELERATOR_IP_ADDRESS  (SRC_IP),
    .ACCELERATOR_MAC_ADDRESS (SRC_MAC),
    .DST_IP_ADDRESS          (DST_IP_ADDRESS),
    .DST_MAC_ADDRESS         (DST_MAC_ADDRESS),
    .DATA_FRAME              (DATA_FRAME),
    .FRAME_VALID             (FRAME_VALID),
    .FRAME_ACCEPT            (FRAME_ACCEPT),
    .MAC_DATA_IN             (MAC_DATA_IN),
    .MAC_DATA_VALID          (MAC_DATA_VALID),
    .MAC_DATA_READY          (MAC_DATA_READY),
    .MAC_DATA_LAST           (MAC_DATA_LAST),
    .TX_BUSY                 (TX_BUSY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  logic [7:0] got [PKT];
  int n_got, last_pos, lat, stall_err, bubble_err, hs_cyc;

  typedef struct {
    logic [15:0] frame;
    logic [31:0] dip;
    int          pct;
    logic [15:0] id;
    logic [15:0] cs;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [47:0] dmac, input logic [31:0] dip,
                                          input logic [15:0] frame, input logic [15:0] id,
                                          input logic [15:0] cs, input int i);
    logic [7:0]  p [PKT];
    logic [47:0] smac;
    logic [31:0] sip;
    smac = SRC_MAC;
    sip  = SRC_IP;
    for (int k = 0; k < 6; k++) begin
      p[k]     = dmac[8*k +: 8];
      p[6 + k] = smac[8*k +: 8];
    end
    p[12] = 8'h08; p[13] = 8'h00; p[14] = 8'h45; p[15] = 8'h00;
    p[16] = 8'h00; p[17] = 8'h16; p[18] = id[15:8]; p[19] = id[7:0];
    p[20] = 8'h40; p[21] = 8'h00; p[22] = 8'h40; p[23] = 8'hFD;
    p[24] = cs[15:8]; p[25] = cs[7:0];
    for (int k = 0; k < 4; k++) begin
      p[26 + k] = sip[8*k +: 8];
      p[30 + k] = dip[8*k +: 8];
    end
    p[34] = frame[7:0]; p[35] = frame[15:8];
    return p[i];
  endfunction

  // Called at a negedge; returns at the negedge right after the capture edge.
  task automatic send_frame(input logic [15:0] frame, input logic [31:0] dip, input logic [47:0] dmac);
    int t = 0;
    DATA_FRAME = frame; DST_IP_ADDRESS = dip; DST_MAC_ADDRESS = dmac;
    FRAME_VALID = 1'b1;
    while (!FRAME_ACCEPT && t < 200) begin @(negedge ACLK); t++; end
    if (t >= 200) chk("accept_timeout", 1, 0);
    hs_cyc = cyc + 1;
    @(negedge ACLK);
    FRAME_VALID = 1'b0;
  endtask

  task automatic collect(input int pct, input bit perturb, input int rst_at);
    bit started = 0, done = 0, pv = 0;
    logic [7:0] pd = 0;
    logic pl = 0;
    int t = 0;
    n_got = 0; last_pos = -1; lat = -1; stall_err = 0; bubble_err = 0;
    while (!done && t < 3000) begin
      if (rst_at >= 0 && n_got == rst_at) begin
        ARESET = 1'b1;
        #1;
        chk("rst_mid_valid", MAC_DATA_VALID, 0);
        chk("rst_mid_last", MAC_DATA_LAST, 0);
        chk("rst_mid_busy", TX_BUSY, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        MAC_DATA_READY = 1'b1;
        return;
      end
      if (perturb && n_got == 3) begin
        DATA_FRAME = 16'h5A5A; DST_IP_ADDRESS = 32'hDEADBEEF; DST_MAC_ADDRESS = 48'h123456789ABC;
      end
      MAC_DATA_READY = ($urandom_range(0, 99) < pct);
      if (pv && (!MAC_DATA_VALID || MAC_DATA_IN !== pd || MAC_DATA_LAST !== pl)) stall_err++;
      if (started && !MAC_DATA_VALID) bubble_err++;
      if (MAC_DATA_VALID && !started) begin lat = t; started = 1; end
      pv = MAC_DATA_VALID && !MAC_DATA_READY;
      pd = MAC_DATA_IN;
      pl = MAC_DATA_LAST;
      if (MAC_DATA_VALID && MAC_DATA_READY) begin
        if (n_got < PKT) got[n_got] = MAC_DATA_IN;
        if (MAC_DATA_LAST) begin last_pos = n_got; done = 1; end
        n_got++;
      end
      @(negedge ACLK);
      t++;
    end
    MAC_DATA_READY = 1'b1;
    if (!done) chk("collect_timeout", 1, 0);
  endtask

  task automatic check_pkt(input string name, input logic [47:0] dmac, input logic [31:0] dip,
                           input logic [15:0] frame, input logic [15:0] id, input logic [15:0] cs);
    chk({name, " len"}, n_got, PKT);
    chk({name, " last_pos"}, last_pos, PKT - 1);
    for (int i = 0; i < PKT; i++)
      chk($sformatf("%s byte%0d", name, i), got[i], exp_byte(dmac, dip, frame, id, cs, i));
    chk({name, " stall_stable"}, stall_err, 0);
    chk({name, " no_bubble"}, bubble_err, 0);
  endtask

  initial begin
    int prev_hs;
    FRAME_VALID = 0; MAC_DATA_READY = 1; DATA_FRAME = 16'hBBAA;
    DST_IP_ADDRESS = DIP_A; DST_MAC_ADDRESS = DMAC_A;

    vecs[0] = '{16'hBBAA, DIP_A,         100, 16'h0000, 16'hB68F};
    vecs[1] = '{16'hBBAA, DIP_A,         100, 16'h0001, 16'hB68E};
    vecs[2] = '{16'hBBAA, DIP_A,          30, 16'h0002, 16'hB68D};
    vecs[3] = '{16'h1234, 32'h0100000A,  100, 16'h0003, 16'h6E35};

    repeat (3) @(negedge ACLK);
    chk("reset_valid", MAC_DATA_VALID, 0);
    chk("reset_last", MAC_DATA_LAST, 0);
    chk("reset_data", MAC_DATA_IN, 0);
    chk("reset_busy", TX_BUSY, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("reset_accept", FRAME_ACCEPT, 1);

    prev_hs = 0;
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].frame, vecs[i].dip, DMAC_A);
      if (i == 1) chk("b2b_spacing", hs_cyc - prev_hs, 38);
      prev_hs = hs_cyc;
      collect(vecs[i].pct, 0, -1);
      check_pkt($sformatf("vec%0d", i), DMAC_A, vecs[i].dip, vecs[i].frame, vecs[i].id, vecs[i].cs);
      if (vecs[i].pct == 100) chk($sformatf("vec%0d latency", i), lat, 1);
      chk($sformatf("vec%0d accept_after", i), FRAME_ACCEPT, 1);
    end

    // Inputs change during the Ethernet header; captured values must win.
    send_frame(16'hBBAA, DIP_A, DMAC_A);
    collect(100, 1, -1);
    check_pkt("isolation", DMAC_A, DIP_A, 16'hBBAA, 16'h0004, 16'hB68B);

    // Identification wrap: 0xFFFF is ones'-complement zero, so the checksum matches ID 0.
    @(negedge ACLK);
    force dut.r_id = 16'hFFFF;
    @(negedge ACLK);
    release dut.r_id;
    send_frame(16'hBBAA, DIP_A, DMAC_A);
    collect(100, 0, -1);
    check_pkt("id_ffff", DMAC_A, DIP_A, 16'hBBAA, 16'hFFFF, 16'hB68F);
    send_frame(16'hBBAA, DIP_A, DMAC_A);
    collect(100, 0, -1);
    check_pkt("id_wrap", DMAC_A, DIP_A, 16'hBBAA, 16'h0000, 16'hB68F);

    // Reset after 20 bytes, then the next packet restarts cleanly with ID 0.
    send_frame(16'hBBAA, DIP_A, DMAC_A);
    send_frame(16'hBBAA, DIP_A, DMAC_A) ;
    collect(100, 0, 20);
    chk("post_rst_accept", FRAME_ACCEPT, 1);
    chk("post_rst_valid", MAC_DATA_VALID, 0);
    send_frame(16'hBBAA, DIP_A, DMAC_A);
    collect(100, 0, -1);
    check_pkt("after_reset", DMAC_A, DIP_A, 16'hBBAA, 16'h0000, 16'hB68F);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
